ifu_pfq: RTL and testbench
==========================

// Module: ifu_pfq
// PURPOSE
// - Parametrised instruction-fetch unit with a prefetch queue; next generation of the core's fetch stage.
// - Streams sequential fetches from the instruction SRAM (1-cycle read latency) into a DEPTH-entry {pc,ins} queue.
// - Consumer (decode/execute) pops with a valid/ready handshake, so the core can stall without losing fetches.
// - Branch redirect flushes the queue, drops the in-flight read and restarts fetch at the target the same cycle.
// PARAMETERS
// - PC_W      32     program-counter width (bits)
// - IA_W      16     instruction SRAM word-address width; ins_a = fpc[IA_W+1:2]
// - DEPTH     4      prefetch queue entries; power of 2, >= 2
// - RESET_PC  32'h0  first fetch address after reset, 4-byte aligned
// PORTS
// - clk      in   1      clock; all state updates on rising edge
// - rst      in   1      asynchronous reset, active-high
// - flush    in   1      redirect: kill queue + in-flight read, fetch from br_adr
// - br_adr   in   PC_W   redirect target; bits [1:0] ignored (treated as 0)
// - ins_a    out  IA_W   SRAM word address
// - ins_e    out  1      SRAM read enable; data on ins in the next cycle
// - ins      in   32     SRAM read data
// - ifu_vld  out  1      queue head valid
// - ifu_rdy  in   1      consumer accepts head; pop = ifu_vld & ifu_rdy & ~flush
// - ifu_pc   out  PC_W   head PC (0 when empty)
// - ifu_ins  out  32     head instruction (NOP 32'h0000_0013 when empty)
// BEHAVIOUR
// - Reset (async, immediate): fpc=RESET_PC, queue empty, in-flight=0; ins_e=0, ifu_vld=0, ifu_pc=0, ifu_ins=NOP.
// - State: fpc, in-flight flag + its pc, queue rd/wr pointers and count (0..DEPTH).
// - Issue rule: ins_e=1 iff (count + infl - pop) < DEPTH, or flush. One read per cycle max, fully pipelined.
// - Issue at cycle t: ins_a=fpc[IA_W+1:2]; fpc <= fpc+4 (mod 2^PC_W); infl<=1 with pc tag. No issue: infl<=0.
// - Response: at t+1 ins is written into the queue with its tagged pc; ifu_vld visible at t+2.
// - Queue never overflows by construction; a write while count==DEPTH is an assertion failure.
// - Simultaneous write+pop: count unchanged, both pointers advance. Pop on empty impossible (ifu_vld=0).
// - ifu_vld = (count != 0); ifu_pc/ifu_ins driven from head entry combinationally off registered state.
// - Flush at cycle t (highest priority): pop suppressed; queue cleared, in-flight response at t+1 discarded;
//   ins_e=1, ins_a=br_adr[IA_W+1:2] in cycle t; fpc <= {br_adr[PC_W-1:2],2'b0}+4. New head valid at t+2.
// - During flush cycle t ifu_vld may still be 1; consumer treats it as killed. From t+1 ifu_vld=0 until refill.
// - Back-to-back flushes: each one restarts; only the last target's stream survives.
// - Wrap: fpc wraps modulo 2^PC_W; ins_a naturally wraps modulo 2^IA_W; no special handling.
// - Reset mid-operation: all state cleared asynchronously; in-flight SRAM data after release is ignored (infl=0).
// - Throughput: 1 instruction/cycle sustained with ifu_rdy=1; DEPTH>=2 required for no-bubble stall recovery.
// STRUCTURE
// - core_pkg: XLEN=32, NOP_INS=32'h0000_0013, typedef struct packed {logic [PC_W-1:0] pc; logic [31:0] ins;} fetch_entry_t.
// - Sub-module ifu_fifo: sync FIFO of fetch_entry_t, DEPTH param, push/pop/clear, count/full/empty outputs.
// - Top holds fpc, in-flight tag, issue logic, flush priority, output muxing.
// TESTING
// - Reset release, ifu_rdy=1, SRAM model returns ins={16'hA5A5,addr} -> ins_a 0,1,2..; ifu_vld from cycle 2; pc 0,4,8 gapless.
// - ifu_rdy=0 from cycle 5 -> exactly DEPTH entries held, ins_e drops to 0; rdy=1 -> in-order, no loss/dup.
// - Full queue + read in flight, flush with br_adr=32'h0000_0103 -> ins_a=16'h0040 same cycle, next vld pc=0x100 at t+2, no stale pc.
// - flush and ifu_rdy=1 same cycle with ifu_vld=1 -> no pop counted, head dropped by flush; scoreboard stays aligned.
// - rst pulsed between edges mid-stream -> outputs reset immediately; after release first ins_a=RESET_PC>>2.
// - RESET_PC=32'h0003_FFFC, IA_W=16 -> ins_a 16'hFFFF then 16'h0000; ifu_pc 0x3FFFC then 0x40000.

Source files
------------

// File: rtl/ifu_pfq_pkg.sv
// Shared fetch-stage types and constants for the prefetching instruction-fetch unit.
package ifu_pfq_pkg;

  localparam int          XLEN    = 32;
  localparam logic [31:0] NOP_INS = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     ins;
  } fetch_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// Synchronous FIFO holding fetched {pc,ins} entries; clear wins over push/pop.
module ifu_fifo #(
  parameter  int W     = 64,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (clear) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) begin
        mem_d[wr_q] = din;
        wr_d        = wr_q + AW'(1);
      end
      if (pop) begin
        rd_d = rd_q + AW'(1);
      end
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '{default: '0};
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign dout  = mem_q[rd_q];
  assign count = cnt_q;
  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == CW'(0));

  ifu_fifo_chk u_chk (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .push  (push),
    .pop   (pop),
    .full  (full)
  );

endmodule

// Overflow guard: the issue logic must never let a write land on a full queue.
module ifu_fifo_chk (
  input logic clk,
  input logic rst,
  input logic clear,
  input logic push,
  input logic pop,
  input logic full
);

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && full && !pop && !clear));

endmodule

// File: rtl/ifu_pfq.sv
// Instruction-fetch unit: streams sequential SRAM reads into a prefetch queue,
// with same-cycle branch redirect that kills queued and in-flight fetches.
module ifu_pfq
  import ifu_pfq_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter int              IA_W     = 16,
  parameter int              DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic [PC_W-1:0] br_adr,
  output logic [IA_W-1:0] ins_a,
  output logic            ins_e,
  input  logic [31:0]     ins,
  output logic            ifu_vld,
  input  logic            ifu_rdy,
  output logic [PC_W-1:0] ifu_pc,
  output logic [31:0]     ifu_ins
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = PC_W + 32;

  logic [PC_W-1:0] fpc_q, fpc_d;
  logic            infl_q, infl_d;
  logic [PC_W-1:0] infl_pc_q, infl_pc_d;

  logic [PC_W-1:0] flush_pc;
  logic [CW:0]     occ;
  logic            pop, push, issue;
  logic [EW-1:0]   head;
  logic [CW-1:0]   count;
  logic            full_s, empty_s;
  logic            unused_bits;

  assign flush_pc    = {br_adr[PC_W-1:2], 2'b00};
  assign unused_bits = ^{br_adr[1:0], full_s};

  // Occupancy after this edge must leave room for the read issued now.
  always_comb begin
    ifu_vld   = ~empty_s;
    pop       = ifu_vld & ifu_rdy & ~flush;
    push      = infl_q & ~flush;
    occ       = {1'b0, count} + (CW+1)'(infl_q) - (CW+1)'(pop);
    issue     = ~rst & (flush | (occ < (CW+1)'(DEPTH)));
    ins_e     = issue;
    fpc_d     = fpc_q;
    infl_d    = issue;
    infl_pc_d = infl_pc_q;
    if (flush) begin
      ins_a     = flush_pc[IA_W+1:2];
      fpc_d     = flush_pc + PC_W'(4);
      infl_pc_d = flush_pc;
    end else if (issue) begin
      ins_a     = fpc_q[IA_W+1:2];
      fpc_d     = fpc_q + PC_W'(4);
      infl_pc_d = fpc_q;
    end else begin
      ins_a     = fpc_q[IA_W+1:2];
    end
    if (ifu_vld) begin
      ifu_pc  = head[EW-1:32];
      ifu_ins = head[31:0];
    end else begin
      ifu_pc  = '0;
      ifu_ins = NOP_INS;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fpc_q     <= RESET_PC;
      infl_q    <= 1'b0;
      infl_pc_q <= '0;
    end else begin
      fpc_q     <= fpc_d;
      infl_q    <= infl_d;
      infl_pc_q <= infl_pc_d;
    end
  end

  ifu_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .push  (push),
    .din   ({infl_pc_q, ins}),
    .pop   (pop),
    .dout  (head),
    .count (count),
    .full  (full_s),
    .empty (empty_s)
  );

endmodule

// File: tb/tb_ifu_pfq.sv
// Scoreboard bench for ifu_pfq: directed stream/stall/flush/reset vectors plus a wrap instance.
module tb_ifu_pfq;
  import ifu_pfq_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [31:0] br_adr = 32'h0;
  logic        ifu_rdy = 1'b0;
  logic [15:0] ins_a;
  logic        ins_e;
  logic [31:0] ins = 32'h0;
  logic        ifu_vld;
  logic [31:0] ifu_pc;
  logic [31:0] ifu_ins;

  logic [15:0] ins_a2;
  logic        ins_e2;
  logic [31:0] ins2 = 32'h0;
  logic        ifu_vld2;
  logic [31:0] ifu_pc2;
  logic [31:0] ifu_ins2;

  fetch_entry_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ifu_pfq #(.PC_W(32), .IA_W(16), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .flush(flush), .br_adr(br_adr),
    .ins_a(ins_a), .ins_e(ins_e), .ins(ins),
    .ifu_vld(ifu_vld), .ifu_rdy(ifu_rdy), .ifu_pc(ifu_pc), .ifu_ins(ifu_ins)
  );

  ifu_pfq #(.PC_W(32), .IA_W(16), .DEPTH(4), .RESET_PC(32'h0003_FFFC)) dut_wrap (
    .clk(clk), .rst(rst), .flush(1'b0), .br_adr(32'h0),
    .ins_a(ins_a2), .ins_e(ins_e2), .ins(ins2),
    .ifu_vld(ifu_vld2), .ifu_rdy(1'b1), .ifu_pc(ifu_pc2), .ifu_ins(ifu_ins2)
  );

  // SRAM models: one-cycle read latency, data tagged with the word address.
  always @(posedge clk) begin
    if (ins_e) ins <= {16'hA5A5, ins_a};
    if (ins_e2) ins2 <= {16'hA5A5, ins_a2};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_seq(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) begin
      fetch_entry_t e;
      e.pc  = start + 32'(4 * i);
      e.ins = {16'hA5A5, e.pc[17:2]};
      exp_q.push_back(e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted head must match the next expected fetch.
  always @(negedge clk) begin
    if (!rst && ifu_vld && ifu_rdy && !flush) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL mon_underflow: got pc %h expected no output", ifu_pc);
      end else begin
        fetch_entry_t e;
        e = exp_q.pop_front();
        chk("mon_pc", ifu_pc, e.pc);
        chk("mon_ins", ifu_ins, e.ins);
      end
    end
  end

  initial begin
    logic [15:0] stall_a;

    step();
    step();
    chk("rst_vld", {31'h0, ifu_vld}, 32'h0);
    chk("rst_ins_e", {31'h0, ins_e}, 32'h0);
    chk("rst_pc", ifu_pc, 32'h0);
    chk("rst_ins", ifu_ins, 32'h0000_0013);

    push_seq(32'h0, 64);
    ifu_rdy = 1'b1;
    rst = 1'b0;
    #1;
    chk("k0_ins_e", {31'h0, ins_e}, 32'h1);
    chk("k0_ins_a", {16'h0, ins_a}, 32'h0);
    chk("k0_vld", {31'h0, ifu_vld}, 32'h0);
    chk("wrap_k0_ins_a", {16'h0, ins_a2}, 32'h0000_FFFF);
    step();
    chk("k1_ins_a", {16'h0, ins_a}, 32'h1);
    chk("k1_vld", {31'h0, ifu_vld}, 32'h0);
    chk("wrap_k1_ins_a", {16'h0, ins_a2}, 32'h0);
    step();
    chk("k2_vld", {31'h0, ifu_vld}, 32'h1);
    chk("k2_ins_a", {16'h0, ins_a}, 32'h2);
    chk("wrap_k2_pc", ifu_pc2, 32'h0003_FFFC);
    chk("wrap_k2_ins", ifu_ins2, 32'hA5A5_FFFF);
    step();
    chk("wrap_k3_pc", ifu_pc2, 32'h0004_0000);
    chk("wrap_k3_ins", ifu_ins2, 32'hA5A5_0000);
    step();
    step();

    // Stall: queue fills to DEPTH, fetch pointer sits DEPTH words past the head.
    ifu_rdy = 1'b0;
    repeat (8) step();
    stall_a = exp_q[0].pc[17:2] + 16'd4;
    chk("stall_ins_e", {31'h0, ins_e}, 32'h0);
    chk("stall_vld", {31'h0, ifu_vld}, 32'h1);
    chk("stall_head_pc", ifu_pc, exp_q[0].pc);
    chk("stall_ins_a", {16'h0, ins_a}, {16'h0, stall_a});
    ifu_rdy = 1'b1;
    repeat (6) step();

    // Redirect while stalled with a read in flight.
    ifu_rdy = 1'b0;
    step();
    flush = 1'b1;
    br_adr = 32'h0000_0103;
    exp_q.delete();
    push_seq(32'h0000_0100, 64);
    #1;
    chk("fl_ins_e", {31'h0, ins_e}, 32'h1);
    chk("fl_ins_a", {16'h0, ins_a}, 32'h0000_0040);
    step();
    flush = 1'b0;
    chk("fl_t1_vld", {31'h0, ifu_vld}, 32'h0);
    step();
    chk("fl_t2_vld", {31'h0, ifu_vld}, 32'h1);
    chk("fl_t2_pc", ifu_pc, 32'h0000_0100);
    ifu_rdy = 1'b1;
    repeat (6) step();

    // Redirect coinciding with a valid, accepted head.
    chk("fl2_pre_vld", {31'h0, ifu_vld}, 32'h1);
    flush = 1'b1;
    br_adr = 32'h0000_0200;
    exp_q.delete();
    push_seq(32'h0000_0200, 64);
    step();
    flush = 1'b0;
    repeat (8) step();

    // Asynchronous reset between edges.
    #2;
    rst = 1'b1;
    #1;
    chk("mrst_vld", {31'h0, ifu_vld}, 32'h0);
    chk("mrst_ins_e", {31'h0, ins_e}, 32'h0);
    chk("mrst_pc", ifu_pc, 32'h0);
    chk("mrst_ins", ifu_ins, 32'h0000_0013);
    exp_q.delete();
    push_seq(32'h0, 64);
    step();
    rst = 1'b0;
    #1;
    chk("mrst_rel_ins_e", {31'h0, ins_e}, 32'h1);
    chk("mrst_rel_ins_a", {16'h0, ins_a}, 32'h0);
    repeat (10) step();
    chk("mrst_progress", {31'h0, (exp_q.size() < 64)}, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
